// File: rtl/serial_paralelo_cond_rx_pkg.sv
// Shared constants and state encoding for the comma-aligned serial-to-parallel receiver.
package serial_paralelo_cond_rx_pkg;

  localparam logic [7:0]  COMMA       = 8'hBC;
  localparam int unsigned COMMA_COUNT = 4;
  localparam int unsigned CNT_W       = 3;

  typedef enum logic [1:0] {
    StSearch  = 2'd0,
    StAligned = 2'd1,
    StActive  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_shift8.sv
// 8-bit MSB-first serial shift register with asynchronous active-low clear.
module serial_shift8 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       bit_i,
  output logic [7:0] data_o
);

  logic [7:0] sh_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q <= '0;
    end else begin
      sh_q <= {sh_q[6:0], bit_i};
    end
  end

  assign data_o = sh_q;

endmodule

// File: rtl/serial_paralelo_cond_rx.sv
// Per-lane receiver: finds byte alignment on the comma, locks after a run of aligned
// commas, then presents each received byte with a valid flag and a one-cycle strobe.
module serial_paralelo_cond_rx
  import serial_paralelo_cond_rx_pkg::*;
#(
  parameter logic [7:0]  Comma      = COMMA,
  parameter int unsigned CommaCount = COMMA_COUNT
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(CommaCount);

  logic [7:0]       sh;
  state_e           state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [CNT_W-1:0] comma_cnt_q;
  logic [CNT_W-1:0] comma_inc;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             strobe_q;
  logic             active_q;
  logic             is_comma;
  logic             boundary;

  serial_shift8 u_shift (
    .clk_i  (clk_32f),
    .rst_ni (reset_L),
    .bit_i  (data_in),
    .data_o (sh)
  );

  assign is_comma = (sh == Comma);
  // bit_cnt is cleared on the edge that consumed the detecting comma, so the
  // window holds a full aligned byte whenever it reads 7.
  assign boundary = (bit_cnt_q == 3'd7);
  assign comma_inc = (comma_cnt_q == CntMax) ? comma_cnt_q : comma_cnt_q + 3'd1;

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= StSearch;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      strobe_q    <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_q + 3'd1;
      strobe_q  <= 1'b0;
      unique case (state_q)
        StSearch: begin
          if (is_comma) begin
            bit_cnt_q   <= '0;
            comma_cnt_q <= 3'd1;
            state_q     <= StAligned;
          end
        end
        StAligned: begin
          if (boundary) begin
            if (is_comma) begin
              comma_cnt_q <= comma_inc;
              if (comma_inc == CntMax) begin
                state_q  <= StActive;
                active_q <= 1'b1;
              end
            end else begin
              comma_cnt_q <= '0;
              state_q     <= StSearch;
            end
          end
        end
        StActive: begin
          if (boundary) begin
            data_q   <= sh;
            valid_q  <= !is_comma;
            strobe_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StSearch;
        end
      endcase
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = active_q;

endmodule

// File: tb/tb_serial_paralelo_cond_rx.sv
// Scoreboard bench: a bit-stream reference model predicts lock point and every strobe.
module tb_serial_paralelo_cond_rx;
  import serial_paralelo_cond_rx_pkg::*;

  localparam int Cc = COMMA_COUNT;

  logic       clk_32f = 1'b0;
  logic       reset_L = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  serial_paralelo_cond_rx dut (
    .clk_32f     (clk_32f),
    .reset_L     (reset_L),
    .data_in     (data_in),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .active      (active)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       valid;
  } exp_t;

  exp_t exp_q[$];
  bit   stream[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc;
  int   act_cyc = -1;
  bit   act_seen = 1'b0;
  int   exp_act = -1;

  always @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic check(string name, int actual, int required);
    vectors++;
    if (actual != required) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, actual, actual, required, required, $time);
    end
  endtask

  // Monitor: every strobe pops one prediction; active's first rise is timestamped.
  initial begin
    forever begin
      @(negedge clk_32f);
      if (reset_L) begin
        if (active && !act_seen) begin
          act_seen = 1'b1;
          act_cyc  = cyc;
        end
        if (byte_strobe) begin
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("strobe_cycle", cyc, e.cyc);
            check("data_out", int'(data_out), int'(e.data));
            check("valid_out", int'(valid_out), int'(e.valid));
          end
        end
      end
    end
  end

  function automatic logic [7:0] win(int n);
    logic [7:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w = {w[6:0], stream[n - 8 + i]};
    return w;
  endfunction

  // Reference: window n = last 8 bits after n bits, judged at edge n+1.
  task automatic build_expect();
    int s, m, k, lock, nbits;
    nbits = stream.size();
    lock  = -1;
    s     = 8;
    forever begin
      m = -1;
      for (int j = s; j < nbits && m < 0; j++) if (win(j) == COMMA) m = j;
      if (m < 0) break;
      k = 1;
      while (k < Cc && m + 8 * k < nbits && win(m + 8 * k) == COMMA) k++;
      if (k == Cc) begin
        lock = m + 8 * (Cc - 1);
        break;
      end
      if (m + 8 * k >= nbits) break;
      s = m + 8 * k + 1;
    end
    exp_act = (lock < 0) ? -1 : lock + 1;
    if (lock >= 0) begin
      for (int n = lock + 8; n < nbits; n += 8) begin
        exp_t e;
        e.cyc   = n + 1;
        e.data  = win(n);
        e.valid = (win(n) != COMMA);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic push_byte(logic [7:0] b);
    for (int i = 7; i >= 0; i--) stream.push_back(b[i]);
  endtask

  task automatic push_rand_bits(int n);
    for (int i = 0; i < n; i++) stream.push_back(1'($urandom));
  endtask

  task automatic push_zero_bits(int n);
    for (int i = 0; i < n; i++) stream.push_back(1'b0);
  endtask

  task automatic check_zero_outputs(string name);
    check({name, "_data_out"}, int'(data_out), 0);
    check({name, "_valid"}, int'(valid_out), 0);
    check({name, "_strobe"}, int'(byte_strobe), 0);
    check({name, "_active"}, int'(active), 0);
  endtask

  task automatic apply_reset();
    reset_L = 1'b0;
    exp_q.delete();
    stream.delete();
    act_seen = 1'b0;
    act_cyc  = -1;
    #1;
    for (int i = 0; i < 3; i++) begin
      data_in = 1'($urandom);
      @(negedge clk_32f);
    end
    check_zero_outputs("reset");
    @(posedge clk_32f);
    #1 reset_L = 1'b1;
  endtask

  task automatic run_stream();
    build_expect();
    for (int i = 0; i < stream.size(); i++) begin
      data_in = stream[i];
      @(posedge clk_32f);
      #1;
    end
    @(negedge clk_32f);
    #1;
  endtask

  task automatic check_end(string name);
    check({name, "_missing_strobes"}, exp_q.size(), 0);
    check({name, "_active_rise_cycle"}, act_cyc, exp_act);
    check({name, "_active_level"}, int'(active), (exp_act >= 0) ? 1 : 0);
  endtask

  initial begin
    logic [7:0] b;

    // Reset, then an all-zero line must never lock.
    apply_reset();
    push_zero_bits(40);
    run_stream();
    check_end("idle_zero");

    // Lock-up after junk bits.
    apply_reset();
    push_rand_bits(3);
    for (int i = 0; i < Cc; i++) push_byte(COMMA);
    push_byte(8'h5A);
    push_byte(COMMA);
    push_byte(8'h3C);
    push_zero_bits(9);
    run_stream();
    check_end("lockup");

    // Broken preamble.
    apply_reset();
    push_byte(COMMA);
    push_byte(COMMA);
    push_byte(8'h11);
    for (int i = 0; i < Cc; i++) push_byte(COMMA);
    push_byte(8'hA5);
    push_zero_bits(1);
    run_stream();
    check_end("broken_preamble");

    // Every bit offset.
    for (int off = 0; off < 8; off++) begin
      apply_reset();
      push_zero_bits(off);
      for (int i = 0; i < Cc; i++) push_byte(COMMA);
      for (int i = 0; i < 3; i++) push_byte(8'($urandom));
      push_zero_bits(1);
      run_stream();
      check_end("offset");
    end

    // Reset mid-byte while active; data without a new preamble must stay silent.
    apply_reset();
    for (int i = 0; i < Cc; i++) push_byte(COMMA);
    push_byte(8'hC3);
    push_byte(8'h7E);
    push_rand_bits(4);
    run_stream();
    check_end("pre_reset");
    reset_L = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    exp_q.delete();
    stream.delete();
    act_seen = 1'b0;
    act_cyc  = -1;
    repeat (3) @(posedge clk_32f);
    #1 reset_L = 1'b1;
    push_byte(8'h12);
    push_byte(8'h34);
    push_byte(8'h56);
    push_byte(8'h78);
    push_byte(8'h9A);
    push_zero_bits(16);
    run_stream();
    check_end("post_reset");

    // Throughput: 64 random non-comma bytes.
    apply_reset();
    for (int i = 0; i < Cc; i++) push_byte(COMMA);
    for (int i = 0; i < 64; i++) begin
      b = 8'($urandom);
      if (b == COMMA) b = 8'h00;
      push_byte(b);
    end
    push_zero_bits(1);
    run_stream();
    check("throughput_strobes_queued", exp_q.size() + 0, 0);
    check_end("throughput");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
